breg_seq: RTL and testbench

- Command sequencer that drives the team's 4x8 dual-read/single-write register file from the initiator side.
- Accepts one ALU command per handshake, reads two operands through the file's read ports, computes an 8-bit result, and writes it back through the file's write port.
- Sits between a command source (test stimulus or a future decoder) and the register file.
- Provides the first executable datapath for the register file.

---
 rtl/breg_seq.sv | 161 ++++++++++++++++
 tb/tb_breg_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/breg_seq.sv
// Command sequencer for the 4x8 dual-read/single-write register file: read, execute, write back.
// Optional BREG_SEQ_FLAGS_EN adds registered zero/carry flag outputs.
module breg_seq #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src0,
  input  logic [AW-1:0] cmd_src1,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] add_rd0,
  output logic [AW-1:0] add_rd1,
  input  logic [DW-1:0] rd0,
  input  logic [DW-1:0] rd1,
  output logic [AW-1:0] add_wr,
  output logic [DW-1:0] wr_data,
  output logic          wr_n,
  output logic          busy,
  output logic          done
`ifdef BREG_SEQ_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_c
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI
  } op_t;

  state_t        r_state, w_next;
  op_t           r_op;
  logic [AW-1:0] r_dst;
  logic [DW-1:0] r_imm;
  logic [AW-1:0] r_add_rd0, r_add_rd1;
  logic [DW-1:0] r_opa, r_opb;
  logic [AW-1:0] r_add_wr;
  logic [DW-1:0] r_wr_data;
  logic [DW-1:0] w_result;

  assign add_rd0 = r_add_rd0;
  assign add_rd1 = r_add_rd1;
  assign add_wr  = r_add_wr;
  assign wr_data = r_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // wr_n decodes from registered state only, so async reset releases it at once.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    wr_n      = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = S_READ;
      end
      S_READ: begin
        busy   = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        busy   = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        done   = 1'b1;
        wr_n   = (r_op == OP_NOP);
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_NOP:  w_result = r_wr_data;
      OP_MOV:  w_result = r_opa;
      OP_ADD:  w_result = r_opa + r_opb;
      OP_SUB:  w_result = r_opa - r_opb;
      OP_AND:  w_result = r_opa & r_opb;
      OP_OR:   w_result = r_opa | r_opb;
      OP_XOR:  w_result = r_opa ^ r_opb;
      OP_LDI:  w_result = r_imm;
      default: w_result = '0;
    endcase
  end

`ifdef BREG_SEQ_FLAGS_EN
  logic w_carry;

  // Carry of a modular add is set exactly when the sum wrapped below A.
  always_comb begin
    w_carry = 1'b0;
    case (r_op)
      OP_ADD:  w_carry = (w_result < r_opa);
      OP_SUB:  w_carry = (r_opa < r_opb);
      default: w_carry = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_NOP;
      r_dst     <= '0;
      r_imm     <= '0;
      r_add_rd0 <= '0;
      r_add_rd1 <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_add_wr  <= '0;
      r_wr_data <= '0;
`ifdef BREG_SEQ_FLAGS_EN
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op      <= op_t'(cmd_op);
            r_dst     <= cmd_dst;
            r_imm     <= cmd_imm;
            r_add_rd0 <= cmd_src0;
            r_add_rd1 <= cmd_src1;
          end
        end
        S_READ: begin
          r_opa <= rd0;
          r_opb <= rd1;
        end
        S_EXEC: begin
          r_add_wr  <= r_dst;
          r_wr_data <= w_result;
`ifdef BREG_SEQ_FLAGS_EN
          if (r_op != OP_NOP) begin
            flag_z <= (w_result == '0);
            flag_c <= w_carry;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_breg_seq.sv
// Bench for breg_seq: behavioural register file, command model and expected-write scoreboard.
module tb_breg_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_dst = '0, cmd_src0 = '0, cmd_src1 = '0;
  logic [7:0] cmd_imm = '0;
  logic       cmd_ready;
  logic [1:0] add_rd0, add_rd1, add_wr;
  logic [7:0] rd0, rd1, wr_data;
  logic       wr_n, busy, done;
`ifdef BREG_SEQ_FLAGS_EN
  logic       flag_z, flag_c;
`endif

  always #5 clk = ~clk;

  breg_seq #(.DW(8), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_imm(cmd_imm),
    .add_rd0(add_rd0), .add_rd1(add_rd1), .rd0(rd0), .rd1(rd1),
    .add_wr(add_wr), .wr_data(wr_data), .wr_n(wr_n),
    .busy(busy), .done(done)
`ifdef BREG_SEQ_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  logic [7:0] rf [4] = '{default: 8'h00};
  assign rd0 = rf[add_rd0];
  assign rd1 = rf[add_rd1];
  always @(posedge clk) if (wr_n === 1'b0) rf[add_wr] <= wr_data;

  int unsigned tests = 0, fails = 0, cyc = 0, wrlow = 0, ndone = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  dst;
    logic [7:0]  data;
    logic        z;
    logic        c;
    int unsigned acc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] m [4] = '{default: 8'h00};
  logic       mz = 1'b0, mc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (wr_n === 1'b0) wrlow++;
      if (done === 1'b1) begin
        ndone++;
        chk("done_has_pending_cmd", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("latency", cyc - e.acc, 2);
          chk("wr_n_in_write", wr_n, (e.op == 3'd0));
          if (e.op != 3'd0) begin
            chk("add_wr", add_wr, e.dst);
            chk("wr_data", wr_data, e.data);
          end
`ifdef BREG_SEQ_FLAGS_EN
          chk("flag_z", flag_z, e.z);
          chk("flag_c", flag_c, e.c);
`endif
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] s0,
                       input logic [1:0] s1, input logic [7:0] imm, input bit keep,
                       input bit track, output int unsigned acc);
    exp_t x;
    logic [8:0] t;
    logic [7:0] a, b;
    int unsigned n;
    cmd_op = op; cmd_dst = dst; cmd_src0 = s0; cmd_src1 = s1; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    acc = 0;
    chk("accept_wait", cmd_ready, 1);
    if (cmd_ready !== 1'b1) begin cmd_valid = 1'b0; return; end
    @(posedge clk); #1;
    acc = cyc;
    chk("ready_low_in_read", cmd_ready, 0);
    chk("busy_in_read", busy, 1);
    if (track) begin
      a = m[s0]; b = m[s1];
      x.op = op; x.dst = dst; x.acc = cyc; x.z = mz; x.c = mc; x.data = 8'h00;
      case (op)
        3'd1: x.data = a;
        3'd2: begin t = {1'b0, a} + {1'b0, b}; x.data = t[7:0]; x.c = t[8]; end
        3'd3: begin x.data = a - b; x.c = (a < b); end
        3'd4: x.data = a & b;
        3'd5: x.data = a | b;
        3'd6: x.data = a ^ b;
        3'd7: x.data = imm;
        default: ;
      endcase
      if (op != 3'd0) begin
        x.z = (x.data == 8'h00);
        if (op != 3'd2 && op != 3'd3) x.c = 1'b0;
        m[dst] = x.data; mz = x.z; mc = x.c;
      end
      sb.push_back(x);
    end
    if (!keep) cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((cmd_ready !== 1'b1 || sb.size() != 0) && n < 40) begin @(negedge clk); n++; end
    chk("idle_wait", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a1, a2, a3, w0, d0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_add_rd0", add_rd0, 0);
    chk("rst_add_rd1", add_rd1, 0);
    chk("rst_add_wr", add_wr, 0);
    chk("rst_wr_data", wr_data, 0);
`ifdef BREG_SEQ_FLAGS_EN
    chk("rst_flag_z", flag_z, 0);
    chk("rst_flag_c", flag_c, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    w0 = wrlow; d0 = ndone;
    issue(3'd7, 2'd1, 2'd0, 2'd0, 8'h5A, 0, 1, a1);
    wait_idle();
    chk("ldi_wr_pulses", wrlow - w0, 1);
    chk("ldi_done_pulses", ndone - d0, 1);
    chk("ldi_rf1", rf[1], 8'h5A);

    issue(3'd7, 2'd0, 2'd0, 2'd0, 8'h0F, 0, 1, a1);
    issue(3'd7, 2'd1, 2'd0, 2'd0, 8'hF1, 0, 1, a1);
    issue(3'd2, 2'd2, 2'd0, 2'd1, 8'h00, 0, 1, a1);
    wait_idle();
    chk("add_rf2", rf[2], 8'h00);
`ifdef BREG_SEQ_FLAGS_EN
    chk("add_flag_z", flag_z, 1);
    chk("add_flag_c", flag_c, 1);
`endif

    issue(3'd7, 2'd0, 2'd0, 2'd0, 8'h00, 0, 1, a1);
    issue(3'd7, 2'd1, 2'd0, 2'd0, 8'h01, 0, 1, a1);
    issue(3'd3, 2'd3, 2'd0, 2'd1, 8'h00, 0, 1, a1);
    wait_idle();
    chk("sub_rf3", rf[3], 8'hFF);
`ifdef BREG_SEQ_FLAGS_EN
    chk("sub_flag_z", flag_z, 0);
    chk("sub_flag_c", flag_c, 1);
`endif

    w0 = wrlow; d0 = ndone;
    issue(3'd7, 2'd2, 2'd0, 2'd0, 8'h3C, 1, 1, a1);
    issue(3'd0, 2'd1, 2'd0, 2'd0, 8'h00, 1, 1, a2);
    issue(3'd1, 2'd0, 2'd2, 2'd2, 8'h00, 0, 1, a3);
    wait_idle();
    chk("b2b_gap_1", a2 - a1, 4);
    chk("b2b_gap_2", a3 - a2, 4);
    chk("b2b_wr_pulses", wrlow - w0, 2);
    chk("b2b_done_pulses", ndone - d0, 3);
    chk("b2b_rf0", rf[0], 8'h3C);
    chk("nop_rf1_kept", rf[1], 8'h01);

    issue(3'd6, 2'd2, 2'd2, 2'd2, 8'h00, 0, 1, a1);
    wait_idle();
    chk("xor_self_rf2", rf[2], 8'h00);

    w0 = wrlow; d0 = ndone;
    issue(3'd2, 2'd3, 2'd0, 2'd1, 8'h00, 0, 0, a1);
    @(posedge clk); #1;
    chk("exec_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_wr_n", wr_n, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mz = 1'b0; mc = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_rf3_kept", rf[3], 8'hFF);
    chk("abort_no_write", wrlow - w0, 0);
    chk("abort_no_done", ndone - d0, 0);
    chk("abort_ready_after", cmd_ready, 1);
`ifdef BREG_SEQ_FLAGS_EN
    chk("abort_flag_z", flag_z, 0);
    chk("abort_flag_c", flag_c, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
